// File: rtl/iq_mag_sqrt_feeder.sv
// rtl/iq_mag_sqrt_feeder.sv - I/Q power computation and sequential square-root feeder/collector
//
// Takes one signed I/Q pair, forms P = I^2 + Q^2 with a shift-add multiplier,
// hands P to an external sequential square-root stage, and returns sqrt(P) and P
// on a valid/ready output handshake.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid/in_ready     sample handshake, in_i/in_q signed W-bit samples
//   sqrt_num/sqrt_valid   P and one-cycle start pulse to the sqrt stage
//   sqrt_res/sqrt_done    root and one-cycle completion pulse from the sqrt stage
//   mag_valid/mag_ready   result handshake, mag_data = floor(sqrt(P)), pwr_data = P
//   err                   one-cycle pulse when the sqrt stage times out

module iq_mag_sqrt_feeder #(
    parameter int W       = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_i,
    input  logic signed [W-1:0] in_q,
    output logic [2*W-1:0]      sqrt_num,
    output logic                sqrt_valid,
    input  logic [W-1:0]        sqrt_res,
    input  logic                sqrt_done,
    output logic                mag_valid,
    input  logic                mag_ready,
    output logic [W-1:0]        mag_data,
    output logic [2*W-1:0]      pwr_data,
    output logic                err
);

    localparam int CW = $clog2(2 * W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        MUL   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state, next_state;
    logic signed [W-1:0]   i_reg, q_reg;
    logic [W-1:0]          abs_q;
    logic [2*W-1:0]        mcand;
    logic [W-1:0]          mplier;
    logic [2*W-1:0]        acc, acc_next;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         tcnt;
    logic                  timeout_warn;

    // Magnitude of the most negative value is 2^(W-1), which fits unsigned W bits.
    function automatic logic [W-1:0] uabs(input logic signed [W-1:0] x);
        uabs = x[W-1] ? (~x + 1'b1) : x;
    endfunction

    assign in_ready = (state == IDLE) & reset;

    always_comb begin
        acc_next     = mplier[0] ? (acc + mcand) : acc;
        // err is registered, so it is raised one cycle early; the final WAIT cycle
        // then carries the pulse and the FSM returns to IDLE right after it.
        timeout_warn = (state == WAIT) && !sqrt_done && (tcnt == TW'(TIMEOUT - 2));
        next_state   = state;
        case (state)
            IDLE:    if (in_valid) next_state = ABS;
            ABS:     next_state = MUL;
            MUL:     if (cnt == CW'(2 * W - 1)) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (tcnt == TW'(TIMEOUT - 1)) next_state = IDLE;
                else if (sqrt_done)           next_state = DONE;
            end
            DONE:    if (mag_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            i_reg      <= '0;
            q_reg      <= '0;
            abs_q      <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            sqrt_num   <= '0;
            sqrt_valid <= 1'b0;
            mag_valid  <= 1'b0;
            mag_data   <= '0;
            pwr_data   <= '0;
            err        <= 1'b0;
        end else begin
            state      <= next_state;
            sqrt_valid <= (next_state == ISSUE);
            mag_valid  <= (next_state == DONE);
            err        <= timeout_warn;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        i_reg <= in_i;
                        q_reg <= in_q;
                    end
                end
                ABS: begin
                    mcand  <= {{W{1'b0}}, uabs(i_reg)};
                    mplier <= uabs(i_reg);
                    abs_q  <= uabs(q_reg);
                    acc    <= '0;
                    cnt    <= '0;
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_next;
                    // First W steps square |I|; then reload both operands with |Q|.
                    if (cnt == CW'(W - 1)) begin
                        mcand  <= {{W{1'b0}}, abs_q};
                        mplier <= abs_q;
                    end else begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (cnt == CW'(2 * W - 1)) sqrt_num <= acc_next;
                end
                ISSUE: tcnt <= '0;
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (next_state == DONE) begin
                        mag_data <= sqrt_res;
                        pwr_data <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
